// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU operation and state encodings
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_none  = 4'd0,
        MDU_mult  = 4'd1,
        MDU_multu = 4'd2,
        MDU_div   = 4'd3,
        MDU_divu  = 4'd4,
        MDU_mthi  = 4'd5,
        MDU_mtlo  = 4'd6,
        MDU_mfhi  = 4'd7,
        MDU_mflo  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    // Only these codes occupy the unit for a multi-cycle busy period.
    function automatic logic is_long_op(input logic [3:0] op);
        return (op == MDU_mult) || (op == MDU_multu) ||
               (op == MDU_div)  || (op == MDU_divu);
    endfunction

    function automatic logic is_mult_op(input logic [3:0] op);
        return (op == MDU_mult) || (op == MDU_multu);
    endfunction

endpackage

// File: rtl/mdu.sv
// rtl/mdu.sv - multi-cycle multiply/divide unit with HI/LO registers
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] result
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0] a_q, b_q;
    mdu_op_e     op_q;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        latch;

    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe, bu_safe;
    logic [31:0] quot_mag, rem_mag, quot_s, rem_s, quot_u, rem_u;

    assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign prod_u = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign a_neg    = a_q[31];
    assign b_neg    = b_q[31];
    assign a_mag    = a_neg ? (32'd0 - a_q) : a_q;
    assign b_mag    = b_neg ? (32'd0 - b_q) : b_q;
    assign b_safe   = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign bu_safe  = (b_q == 32'd0) ? 32'd1 : b_q;
    assign quot_mag = a_mag / b_safe;
    assign rem_mag  = a_mag % b_safe;
    assign quot_s   = (a_neg ^ b_neg) ? (32'd0 - quot_mag) : quot_mag;
    assign rem_s    = a_neg ? (32'd0 - rem_mag) : rem_mag;
    assign quot_u   = a_q / bu_safe;
    assign rem_u    = a_q % bu_safe;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        latch   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && is_long_op(MDUOp)) begin
                    latch   = 1'b1;
                    state_d = S_RUN;
                    cnt_d   = is_mult_op(MDUOp) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                end else if (MDUOp == MDU_mthi) begin
                    hi_d = A;
                end else if (MDUOp == MDU_mtlo) begin
                    lo_d = A;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    case (op_q)
                        MDU_mult:  {hi_d, lo_d} = prod_s;
                        MDU_multu: {hi_d, lo_d} = prod_u;
                        MDU_div: begin
                            if (b_q != 32'd0) begin
                                hi_d = rem_s;
                                lo_d = quot_s;
                            end
                        end
                        MDU_divu: begin
                            if (b_q != 32'd0) begin
                                hi_d = rem_u;
                                lo_d = quot_u;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= MDU_none;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (latch) begin
                a_q  <= A;
                b_q  <= B;
                op_q <= mdu_op_e'(MDUOp);
            end
        end
    end

    assign busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        result = 32'd0;
        if (MDUOp == MDU_mfhi)
            result = hi_q;
        else if (MDUOp == MDU_mflo)
            result = lo_q;
    end

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - randomized self-checking bench for mdu against an arithmetic model
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b;
    logic [3:0]  op;
    logic        start;
    logic        busy;
    logic [31:0] hi, lo, result;

    int tests = 0;
    int fails = 0;
    logic [31:0] hi_m, lo_m;

    mdu dut (
        .clk    (clk),
        .reset  (rst_n),
        .A      (a),
        .B      (b),
        .MDUOp  (op),
        .start  (start),
        .busy   (busy),
        .HI     (hi),
        .LO     (lo),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [3:0] o, input logic [31:0] x,
                                               input logic [31:0] y, input logic [31:0] h,
                                               input logic [31:0] l);
        longint sx, sy, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            MDU_mult:  return 64'(sx * sy);
            MDU_multu: return {32'd0, x} * {32'd0, y};
            MDU_div: begin
                if (y == 32'd0) return {h, l};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            MDU_divu: begin
                if (y == 32'd0) return {h, l};
                return {x % y, x / y};
            end
            default: return {h, l};
        endcase
    endfunction

    task automatic read_check(input string tag);
        op = MDU_mfhi;
        #1 check({tag, "_mfhi"}, result, hi_m);
        op = MDU_mflo;
        #1 check({tag, "_mflo"}, result, lo_m);
        op = MDU_none;
        #1 check({tag, "_none"}, result, 32'd0);
    endtask

    // Called at a negedge; returns at a negedge with the unit idle.
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit noisy, input string tag);
        int n;
        int exp_n;
        logic [63:0] e;
        e     = ref_result(o, x, y, hi_m, lo_m);
        exp_n = (o == MDU_mult || o == MDU_multu) ? 5 : 10;
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = MDU_none;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            a = $urandom;
            b = $urandom;
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                op    = 4'($urandom_range(0, 15));
            end
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0; op = MDU_none;
        check({tag, "_busy"}, 64'(n), 64'(exp_n));
        hi_m = e[63:32];
        lo_m = e[31:0];
        check({tag, "_hi"}, hi, hi_m);
        check({tag, "_lo"}, lo, lo_m);
    endtask

    task automatic move_to(input logic [3:0] o, input logic [31:0] x, input string tag);
        op = o; a = x;
        @(posedge clk);
        @(negedge clk);
        op = MDU_none;
        if (o == MDU_mthi) hi_m = x; else lo_m = x;
        check({tag, "_hi"}, hi, hi_m);
        check({tag, "_lo"}, lo, lo_m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rop;
        logic [31:0] rx, ry;
        rst_n = 1'b0; a = '0; b = '0; op = MDU_none; start = 1'b0;
        hi_m = '0; lo_m = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        rst_n = 1'b1;

        run_op(MDU_mult,  32'hFFFF_FFFE, 32'd3, 1'b0, "t1_mult");
        run_op(MDU_multu, 32'hFFFF_FFFF, 32'd2, 1'b0, "t2_multu");
        run_op(MDU_div,   32'hFFFF_FFF9, 32'd2, 1'b0, "t3_div");
        check("t3_lo_const", lo, 32'hFFFF_FFFD);
        check("t3_hi_const", hi, 32'hFFFF_FFFF);

        move_to(MDU_mthi, 32'h1234_5678, "t4_mthi");
        run_op(MDU_divu, 32'hDEAD_BEEF, 32'd0, 1'b0, "t4_divu0");
        check("t4_hi_const", hi, 32'h1234_5678);
        read_check("t4");

        run_op(MDU_div, 32'd1000, 32'hFFFF_FFF9, 1'b1, "t5_noisy_div");
        run_op(MDU_div, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "ovf_div");
        check("ovf_lo_const", lo, 32'h8000_0000);
        check("ovf_hi_const", hi, 32'd0);
        move_to(MDU_mtlo, 32'hCAFE_F00D, "mtlo");

        // Start qualified with non-long or undefined codes must not occupy the unit.
        start = 1'b1; op = MDU_mfhi;
        @(posedge clk); @(negedge clk);
        check("start_mfhi_busy", busy, 1'b0);
        op = 4'hF;
        @(posedge clk); @(negedge clk);
        start = 1'b0; op = MDU_none;
        check("start_undef_busy", busy, 1'b0);
        check("undef_hi", hi, hi_m);
        check("undef_lo", lo, lo_m);

        // Test 6: asynchronous reset in the middle of a multiply.
        op = MDU_mult; a = 32'h0000_1234; b = 32'h0000_5678; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0; op = MDU_none;
        @(posedge clk); @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy", busy, 1'b0);
        check("t6_hi", hi, 32'd0);
        check("t6_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hi_m = '0; lo_m = '0;
        run_op(MDU_mult, 32'h8000_0000, 32'h8000_0000, 1'b0, "t6_after");

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(1, 4));
            rx  = $urandom;
            ry  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) ry = ry >> $urandom_range(0, 31);
            run_op(rop, rx, ry, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
            if (i % 8 == 0) read_check($sformatf("rnd%0d", i));
            if (i % 10 == 5) move_to(MDU_mthi, $urandom, $sformatf("rnd%0d_mthi", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
